// File: rtl/red_seq_pkg.sv
// Shared constants for the RED (byte-reduction) sequencer: FSM encoding,
// latency and datapath widths, plus the 9th-bit helper for signed byte sums.
package red_seq_pkg;

    localparam int WIDTH   = 16;
    localparam int ADDER_W = 4;
    localparam int RED_LAT = 7;

    localparam logic [3:0] ST_IDLE = 4'd0;
    localparam logic [3:0] ST_LO0  = 4'd1;
    localparam logic [3:0] ST_LO1  = 4'd2;
    localparam logic [3:0] ST_HI0  = 4'd3;
    localparam logic [3:0] ST_HI1  = 4'd4;
    localparam logic [3:0] ST_F0   = 4'd5;
    localparam logic [3:0] ST_F1   = 4'd6;
    localparam logic [3:0] ST_F2   = 4'd7;
    localparam logic [3:0] ST_DONE = 4'd8;

    // a7 ^ b7 ^ cout7 rewritten on the carry into bit 7: equal signs give that
    // sign, differing signs give the inverted incoming carry.
    function automatic logic sign9(input logic a_msb, input logic b_msb, input logic c_msb);
        logic r;
        if (a_msb == b_msb) begin
            r = a_msb;
        end else begin
            r = ~c_msb;
        end
        return r;
    endfunction

endpackage

// File: rtl/red_add4.sv
// Shared 4-bit carry-lookahead slice; c3 is the carry into the top bit so the
// caller can form the sign-extension bit of a signed sum.
module red_add4
    import red_seq_pkg::*;
(
    input  logic [ADDER_W-1:0] a,
    input  logic [ADDER_W-1:0] b,
    input  logic               cin,
    output logic [ADDER_W-1:0] sum,
    output logic               cout,
    output logic               c3
);

    logic [ADDER_W-1:0] p_s;
    logic [ADDER_W-1:0] g_s;
    logic               c1_s;
    logic               c2_s;

    assign p_s  = a ^ b;
    assign g_s  = a & b;
    assign c1_s = g_s[0] | (p_s[0] & cin);
    assign c2_s = g_s[1] | (p_s[1] & g_s[0]) | (p_s[1] & p_s[0] & cin);
    assign c3   = g_s[2] | (p_s[2] & g_s[1]) | (p_s[2] & p_s[1] & g_s[0])
                | (p_s[2] & p_s[1] & p_s[0] & cin);
    assign cout = g_s[3] | (p_s[3] & g_s[2]) | (p_s[3] & p_s[2] & g_s[1])
                | (p_s[3] & p_s[2] & p_s[1] & g_s[0])
                | (p_s[3] & p_s[2] & p_s[1] & p_s[0] & cin);
    assign sum  = p_s ^ {c3, c2_s, c1_s, cin};

endmodule

// File: rtl/red_seq_ctrl.sv
// RED sequencer: sums the signed byte pairs of A and B, then adds the two
// 9-bit partials, all through one 4-bit slice over seven cycles.
module red_seq_ctrl #(
    parameter int WIDTH   = red_seq_pkg::WIDTH,
    parameter int ADDER_W = red_seq_pkg::ADDER_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Out,
    output logic             busy
);
    import red_seq_pkg::*;

    logic [3:0]         state_r;
    logic [3:0]         next_state_s;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic [8:0]         lo_r;
    logic [8:0]         hi_r;
    logic [7:0]         res_lo_r;
    logic               carry_r;
    logic [WIDTH-1:0]   out_r;
    logic [ADDER_W-1:0] add_a_s;
    logic [ADDER_W-1:0] add_b_s;
    logic [ADDER_W-1:0] add_sum_s;
    logic               add_cout_s;
    logic               add_c3_s;
    logic               sign_s;

    // Next-state sequencing; flush overrides everything
    always_comb begin
        next_state_s = state_r;
        if (flush) begin
            next_state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: next_state_s = in_valid ? ST_LO0 : ST_IDLE;
                ST_LO0:  next_state_s = ST_LO1;
                ST_LO1:  next_state_s = ST_HI0;
                ST_HI0:  next_state_s = ST_HI1;
                ST_HI1:  next_state_s = ST_F0;
                ST_F0:   next_state_s = ST_F1;
                ST_F1:   next_state_s = ST_F2;
                ST_F2:   next_state_s = ST_DONE;
                ST_DONE: next_state_s = out_ready ? ST_IDLE : ST_DONE;
                default: next_state_s = ST_IDLE;
            endcase
        end
    end

    // Operand mux for the shared slice; F2 adds the sign-extension nibbles
    always_comb begin
        add_a_s = 4'h0;
        add_b_s = 4'h0;
        case (state_r)
            ST_LO0:  begin add_a_s = a_r[3:0];      add_b_s = b_r[3:0];      end
            ST_LO1:  begin add_a_s = a_r[7:4];      add_b_s = b_r[7:4];      end
            ST_HI0:  begin add_a_s = a_r[11:8];     add_b_s = b_r[11:8];     end
            ST_HI1:  begin add_a_s = a_r[15:12];    add_b_s = b_r[15:12];    end
            ST_F0:   begin add_a_s = hi_r[3:0];     add_b_s = lo_r[3:0];     end
            ST_F1:   begin add_a_s = hi_r[7:4];     add_b_s = lo_r[7:4];     end
            ST_F2:   begin add_a_s = {4{hi_r[8]}};  add_b_s = {4{lo_r[8]}};  end
            default: begin add_a_s = 4'h0;          add_b_s = 4'h0;          end
        endcase
    end

    red_add4 u_add4 (
        .a    (add_a_s),
        .b    (add_b_s),
        .cin  (carry_r),
        .sum  (add_sum_s),
        .cout (add_cout_s),
        .c3   (add_c3_s)
    );

    assign sign_s = sign9(add_a_s[3], add_b_s[3], add_c3_s);

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Operand capture, partial sums, carry chain and result register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r      <= 16'h0000;
            b_r      <= 16'h0000;
            lo_r     <= 9'h000;
            hi_r     <= 9'h000;
            res_lo_r <= 8'h00;
            carry_r  <= 1'b0;
            out_r    <= 16'h0000;
        end else if (flush) begin
            carry_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_r <= A;
                        b_r <= B;
                    end
                    carry_r <= 1'b0;
                end
                ST_LO0: begin lo_r[3:0] <= add_sum_s; carry_r <= add_cout_s; end
                ST_LO1: begin lo_r[8:4] <= {sign_s, add_sum_s}; carry_r <= 1'b0; end
                ST_HI0: begin hi_r[3:0] <= add_sum_s; carry_r <= add_cout_s; end
                ST_HI1: begin hi_r[8:4] <= {sign_s, add_sum_s}; carry_r <= 1'b0; end
                ST_F0:  begin res_lo_r[3:0] <= add_sum_s; carry_r <= add_cout_s; end
                ST_F1:  begin res_lo_r[7:4] <= add_sum_s; carry_r <= add_cout_s; end
                ST_F2: begin
                    out_r   <= {{4{add_sum_s[3]}}, add_sum_s, res_lo_r};
                    carry_r <= 1'b0;
                end
                ST_DONE: carry_r <= 1'b0;
                default: carry_r <= 1'b0;
            endcase
        end
    end

    assign in_ready  = (state_r == ST_IDLE) && !flush;
    assign out_valid = (state_r == ST_DONE);
    assign busy      = (state_r != ST_IDLE);
    assign Out       = out_r;

endmodule
